// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant held under a
// valid/ready handshake. The grant feeds a one-hot-to-binary encoder
// downstream to form a slot/tag index (issue select, free-entry allocation).
module rr_onehot_arbiter #(
  parameter int N = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 flush,
  input  logic                 ready,
  output logic                 grant_valid,
  output logic [N-1:0]         grant_oh,
  output logic [$clog2(N)-1:0] ptr
);

  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [PW-1:0] ptr_q, ptr_d;

  logic [PW-1:0] grant_idx;
  logic [PW-1:0] after_grant_idx;
  logic [N-1:0]  first_grant;
  logic [N-1:0]  next_grant;

  // One-hot of the first set bit of r scanning upward from p with wrap-around.
  function automatic logic [N-1:0] sel(input logic [N-1:0] r, input logic [PW-1:0] p);
    logic [N-1:0]  result;
    logic          found;
    logic [PW-1:0] k_idx;
    int            k;
    result = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = int'(p) + i;
      if (k >= N) k = k - N;
      k_idx = PW'(k);
      if (!found && r[k_idx]) begin
        result[k_idx] = 1'b1;
        found         = 1'b1;
      end
    end
    return result;
  endfunction

  // Binary index of a one-hot vector (zero for an all-zero vector).
  function automatic logic [PW-1:0] onehot_idx(input logic [N-1:0] g);
    logic [PW-1:0] result;
    result = '0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) result = result | PW'(i);
    end
    return result;
  endfunction

  assign grant_idx       = onehot_idx(grant_q);
  assign after_grant_idx = (grant_idx == LAST_IDX) ? '0 : grant_idx + PW'(1);
  assign first_grant     = sel(req, ptr_q);
  // The requester just served is masked out so it cannot win twice in a row.
  assign next_grant      = sel(req & ~grant_q, after_grant_idx);

  // Next-state: flush kills everything, IDLE launches a grant, HOLD waits for accept.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (flush) begin
      state_d = IDLE;
      grant_d = '0;
    end else if (state_q == IDLE) begin
      if (req != '0) begin
        state_d = HOLD;
        grant_d = first_grant;
      end
    end else if (ready) begin
      ptr_d = after_grant_idx;
      if (next_grant != '0) begin
        state_d = HOLD;
        grant_d = next_grant;
      end else begin
        state_d = IDLE;
        grant_d = '0;
      end
    end
  end

  // State registers; reset drops any grant in flight immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant_valid = (state_q == HOLD);
  assign grant_oh    = grant_q;
  assign ptr         = ptr_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter at N=8: reset, rotation, wrap select,
// hold stability, flush priority, single requester and async mid-grant reset.
module tb_rr_onehot_arbiter;

  localparam int N = 8;

  logic         clock;
  logic         reset;
  logic [N-1:0] req;
  logic         flush;
  logic         ready;
  logic         grant_valid;
  logic [N-1:0] grant_oh;
  logic [2:0]   ptr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] req;
    logic       flush;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_grant;
    logic [2:0] exp_ptr;
  } vec_t;

  vec_t vecs[$];

  rr_onehot_arbiter #(.N(N)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .flush       (flush),
    .ready       (ready),
    .grant_valid (grant_valid),
    .grant_oh    (grant_oh),
    .ptr         (ptr)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drive one set of inputs, then let one rising edge pass and settle.
  task automatic applyStimulus(input logic [7:0] r, input logic f, input logic rd);
    req   = r;
    flush = f;
    ready = rd;
    @(posedge clock);
    #1;
  endtask

  // Compare all three outputs against hand-computed values.
  task automatic checkOutput(input int step, input logic ev, input logic [7:0] eg, input logic [2:0] ep);
    checks++;
    if (grant_valid !== ev) begin
      failures++;
      $display("[TB] FAIL step%0d grant_valid got=%0b want=%0b", step, grant_valid, ev);
    end
    checks++;
    if (grant_oh !== eg) begin
      failures++;
      $display("[TB] FAIL step%0d grant_oh got=%h want=%h", step, grant_oh, eg);
    end
    checks++;
    if (ptr !== ep) begin
      failures++;
      $display("[TB] FAIL step%0d ptr got=%0d want=%0d", step, ptr, ep);
    end
  endtask

  // Invariants: one-hot grant when valid, zero grant when not, ptr moves only on accept.
  logic       prev_saved = 1'b0;
  logic       prev_accept;
  logic [2:0] prev_ptr;

  always @(posedge clock) begin
    prev_accept = grant_valid && ready && !flush;
    prev_ptr    = ptr;
    prev_saved  = reset;
  end

  always @(negedge clock) begin
    if (reset) begin
      checks++;
      if (grant_valid ? !$onehot(grant_oh) : (grant_oh != '0)) begin
        failures++;
        $display("[TB] FAIL inv_onehot grant_oh=%h grant_valid=%0b", grant_oh, grant_valid);
      end
      if (prev_saved) begin
        checks++;
        if (!prev_accept && ptr != prev_ptr) begin
          failures++;
          $display("[TB] FAIL inv_ptr got=%0d want=%0d", ptr, prev_ptr);
        end
      end
    end
  end

  initial begin
    // Rotation with everyone requesting and ready held high.
    vecs.push_back('{8'hFF, 1'b0, 1'b1, 1'b1, 8'h01, 3'd0});
    vecs.push_back('{8'hFF, 1'b0, 1'b1, 1'b1, 8'h02, 3'd1});
    vecs.push_back('{8'hFF, 1'b0, 1'b1, 1'b1, 8'h04, 3'd2});
    vecs.push_back('{8'hFF, 1'b0, 1'b1, 1'b1, 8'h08, 3'd3});
    vecs.push_back('{8'hFF, 1'b0, 1'b1, 1'b1, 8'h10, 3'd4});
    vecs.push_back('{8'hFF, 1'b0, 1'b1, 1'b1, 8'h20, 3'd5});
    vecs.push_back('{8'hFF, 1'b0, 1'b1, 1'b1, 8'h40, 3'd6});
    vecs.push_back('{8'hFF, 1'b0, 1'b1, 1'b1, 8'h80, 3'd7});
    vecs.push_back('{8'hFF, 1'b0, 1'b1, 1'b1, 8'h01, 3'd0});
    // Walk ptr up to 6.
    vecs.push_back('{8'hFF, 1'b0, 1'b1, 1'b1, 8'h02, 3'd1});
    vecs.push_back('{8'hFF, 1'b0, 1'b1, 1'b1, 8'h04, 3'd2});
    vecs.push_back('{8'hFF, 1'b0, 1'b1, 1'b1, 8'h08, 3'd3});
    vecs.push_back('{8'hFF, 1'b0, 1'b1, 1'b1, 8'h10, 3'd4});
    vecs.push_back('{8'hFF, 1'b0, 1'b1, 1'b1, 8'h20, 3'd5});
    vecs.push_back('{8'hFF, 1'b0, 1'b1, 1'b1, 8'h40, 3'd6});
    // Flush beats ready while holding 0x40: ptr stays 6.
    vecs.push_back('{8'h05, 1'b1, 1'b1, 1'b0, 8'h00, 3'd6});
    // Wrap select from ptr 6 with req 0x05.
    vecs.push_back('{8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 3'd6});
    vecs.push_back('{8'h05, 1'b0, 1'b1, 1'b1, 8'h04, 3'd1});
    vecs.push_back('{8'h05, 1'b0, 1'b0, 1'b1, 8'h04, 3'd1});
    // Hold 0x08 while req wanders and drops bit 3.
    vecs.push_back('{8'h08, 1'b0, 1'b1, 1'b1, 8'h08, 3'd3});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 1'b1, 8'h08, 3'd3});
    vecs.push_back('{8'h08, 1'b0, 1'b0, 1'b1, 8'h08, 3'd3});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 1'b1, 8'h08, 3'd3});
    vecs.push_back('{8'hF7, 1'b0, 1'b0, 1'b1, 8'h08, 3'd3});
    vecs.push_back('{8'h00, 1'b0, 1'b0, 1'b1, 8'h08, 3'd3});
    vecs.push_back('{8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd4});
    // Flush in IDLE blocks a grant; then flush+ready on a held 0x10.
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 3'd4});
    vecs.push_back('{8'h10, 1'b0, 1'b0, 1'b1, 8'h10, 3'd4});
    vecs.push_back('{8'h10, 1'b1, 1'b1, 1'b0, 8'h00, 3'd4});
    // Single requester: grant, bubble, grant.
    vecs.push_back('{8'h20, 1'b0, 1'b1, 1'b1, 8'h20, 3'd4});
    vecs.push_back('{8'h20, 1'b0, 1'b1, 1'b0, 8'h00, 3'd6});
    vecs.push_back('{8'h20, 1'b0, 1'b1, 1'b1, 8'h20, 3'd6});
    vecs.push_back('{8'h20, 1'b0, 1'b1, 1'b0, 8'h00, 3'd6});
    vecs.push_back('{8'h20, 1'b0, 1'b1, 1'b1, 8'h20, 3'd6});

    reset = 1'b0;
    req   = '0;
    flush = 1'b0;
    ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput(-1, 1'b0, 8'h00, 3'd0);
    reset = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput(-2, 1'b0, 8'h00, 3'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, vecs[i].flush, vecs[i].ready);
      checkOutput(i, vecs[i].exp_valid, vecs[i].exp_grant, vecs[i].exp_ptr);
    end

    // Async reset in the middle of a held grant takes effect without a clock edge.
    req   = 8'hFF;
    ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checkOutput(100, 1'b0, 8'h00, 3'd0);
    @(negedge clock);
    #1;
    reset = 1'b1;
    applyStimulus(8'hFF, 1'b0, 1'b0);
    checkOutput(101, 1'b1, 8'h01, 3'd0);
    applyStimulus(8'hFF, 1'b0, 1'b0);
    checkOutput(102, 1'b1, 8'h01, 3'd0);

    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_onehot_arbiter.md
Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter that picks one requester from an N-bit request vector per handshake.
- Presents the winner as a registered one-hot grant, held under a valid/ready handshake.
- Sits directly upstream of the team's one-hot-to-binary encoder: grant_oh feeds that encoder to form a slot/tag index.
- Used for reservation-station issue select and free-entry allocation.

Parameters:
- N, 32, number of requesters; N >= 2. Pointer width is $clog2(N).

Ports:
- clock, input, 1, system clock; all state updates on posedge.
- reset, input, 1, asynchronous active-low reset; asserting (0) clears state immediately.
- req, input, N, request vector; bit i = requester i wants service. Sampled every cycle.
- flush, input, 1, synchronous kill of any outstanding grant (branch mispredict recovery).
- ready, input, 1, downstream accepts the current grant this cycle.
- grant_valid, output, 1, grant_oh holds a valid winner.
- grant_oh, output, N, registered one-hot winner; all-zero when grant_valid=0.
- ptr, output, $clog2(N), current highest-priority index (debug/verification visibility).

Behaviour:
- Reset (reset=0, async):
  - grant_valid=0, grant_oh=0, ptr=0, state=IDLE.
  - Applies mid-grant too; a grant in flight is dropped without handshake.
- States: IDLE (no grant held), HOLD (grant_valid=1).
- Selection function sel(r, p):
  - Returns a one-hot vector for the lowest index i, scanning p, p+1, ..., N-1, 0, ..., p-1 (wrap-around), with r[i]=1.
  - Returns all-zero if r=0.
  - Combinational, computed from registered ptr.
- IDLE:
  - If flush=1, stay IDLE.
  - Else if req!=0: next cycle grant_oh=sel(req,ptr), grant_valid=1, go to HOLD.
  - Else stay IDLE.
  - Latency is 1 cycle from req to grant_valid.
- HOLD:
  - grant_oh and grant_valid stay stable until accepted or flushed.
  - They stay stable even if the granted req bit drops; the downstream owns the grant once offered.
  - Accept = ready=1 and flush=0 in HOLD. On accept:
    - ptr <= (idx(grant_oh)+1) mod N; wraps N-1 -> 0.
    - Next grant = sel(req & ~grant_oh, idx(grant_oh)+1 mod N). The just-served requester is excluded for one cycle, guaranteeing no back-to-back repeat.
    - If the next grant is nonzero, stay in HOLD with the new grant (back-to-back, no bubble).
    - Otherwise grant_valid=0, grant_oh=0, go to IDLE.
  - ready=0: hold; ptr unchanged.
- flush=1 (any state):
  - Next cycle grant_valid=0, grant_oh=0, state=IDLE, ptr unchanged.
  - flush has priority over ready.
- ready in IDLE is ignored.
- Invariants (bench asserts):
  - grant_oh is one-hot whenever grant_valid=1.
  - grant_oh=0 whenever grant_valid=0.
  - ptr changes only on accept.
- Fairness: with all bits continuously requesting, each requester is granted exactly once per N accepts.

Test Plan:
- Reset: drive reset=0 with req=8'hFF mid-HOLD, N=8 -> grant_valid=0, grant_oh=0, ptr=0 immediately; after release, next cycle grant_oh=8'h01.
- Rotation: N=8, req=8'hFF, ready=1 constant -> grant_oh sequence 01,02,04,...,80,01 on consecutive cycles, no bubbles; ptr follows 1,2,...,7,0.
- Wrap select: ptr=6, req=8'b0000_0101 -> grant_oh=8'h01; after accept ptr=1; next grant 8'h04.
- Hold/stability: grant_oh=8'h08 with ready=0 for 5 cycles while req toggles/drops bit 3 -> grant_oh stays 8'h08, ptr unchanged; ready=1 -> ptr=4.
- Flush priority: HOLD with grant 8'h10, flush=1 and ready=1 same cycle -> next cycle grant_valid=0, ptr unchanged; flush in IDLE with req!=0 -> no grant that cycle.
- Single requester: req=8'h20 constant, ready=1 -> grant on cycle 1, IDLE bubble (self excluded), grant again on cycle 3; grant count = accepts.
